icache_ctrl: RTL and testbench

Direct-mapped, read-only instruction cache controller that answers the PC stage's fetch address and returns the instruction word. On a miss it raises `hold_o` (wired to the PC's `hold_i`) and refills a 4-word line from instruction memory over a request/acknowledge word interface. It sits between the PC register and the instruction memory in the fetch stage.

---
 rtl/icache_ctrl.sv | 125 ++++++++++++
 tb/tb_icache_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache with a 4-word line refill over a req/ack word port.
// Define ICACHE_STATS_EN to add the hit_cnt_o / miss_cnt_o statistics counters.
module icache_ctrl #(
  parameter int INDEX_BITS = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [31:0] pc_i,
  input  logic        invalidate_i,
  output logic [31:0] inst_o,
  output logic        hold_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 28 - INDEX_BITS;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t                  state;
  logic [LINES-1:0]        valid;
  logic [TAG_W-1:0]        tags [LINES];
  logic [31:0]             data [LINES][4];
  logic [27:0]             miss_addr;
  logic [1:0]              k;
  logic                    drop;

  logic [1:0]              word_sel;
  logic [INDEX_BITS-1:0]   index;
  logic [TAG_W-1:0]        tag;
  logic [INDEX_BITS-1:0]   miss_idx;
  logic [TAG_W-1:0]        miss_tag;
  logic                    lookup_hit;
  logic                    hit;
  logic                    miss;
  logic                    unused_bits;

  assign word_sel    = pc_i[3:2];
  assign index       = pc_i[3+INDEX_BITS:4];
  assign tag         = pc_i[31:4+INDEX_BITS];
  assign miss_idx    = miss_addr[INDEX_BITS-1:0];
  assign miss_tag    = miss_addr[27:INDEX_BITS];
  assign unused_bits = ^pc_i[1:0];

  assign lookup_hit = valid[index] && (tags[index] == tag);
  assign hit        = (state == IDLE) && req_i && lookup_hit;
  assign miss       = (state == IDLE) && req_i && !lookup_hit;

  // Outputs are forced low while reset is held so the PC stage is released immediately.
  assign hold_o = rst_i && ((state == REFILL) || miss);
  assign inst_o = (rst_i && hit) ? data[index][word_sel] : 32'd0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      valid      <= '0;
      miss_addr  <= '0;
      k          <= 2'd0;
      drop       <= 1'b0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (invalidate_i) valid <= '0;
          if (miss) begin
            miss_addr  <= pc_i[31:4];
            k          <= 2'd0;
            mem_req_o  <= 1'b1;
            mem_addr_o <= {pc_i[31:4], 4'b0000};
            state      <= REFILL;
          end
        end
        REFILL: begin
          if (invalidate_i) begin
            valid <= '0;
            drop  <= 1'b1;
          end
          if (mem_ack_i) begin
            k          <= k + 2'd1;
            mem_addr_o <= {miss_addr, k + 2'd1, 2'b00};
            // An invalidate seen at any point of the refill leaves the line invalid.
            if (k == 2'd3) begin
              mem_req_o <= 1'b0;
              drop      <= 1'b0;
              state     <= IDLE;
              if (!drop && !invalidate_i) valid[miss_idx] <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data storage need no reset; the valid bits qualify them.
  always_ff @(posedge clk_i) begin
    if (state == REFILL && mem_ack_i) begin
      data[miss_idx][k] <= mem_data_i;
      if (k == 2'd3) tags[miss_idx] <= miss_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_o  <= 32'd0;
      miss_cnt_o <= 32'd0;
    end else begin
      if (hit)  hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (miss) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: a residency map predicts hit/miss, stall length, refill
// addresses and returned words; a negedge monitor compares whatever the DUT presents.
module tb_icache_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_i = 1'b0;
  logic [31:0] pc_i = 32'd0;
  logic        invalidate_i = 1'b0;
  logic [31:0] inst_o;
  logic        hold_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;
`endif

  int checks = 0;
  int passes = 0;
  int wait_states = 0;
  int wcnt = 0;
  bit mon_en = 1'b0;
  int held = 0;
  bit prev_wait = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  int exp_hits = 0;
  int exp_misses = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    int          hold;
  } exp_t;

  exp_t        sbq [$];
  logic [31:0] addrq [$];
  logic [27:0] resident [int];

  icache_ctrl #(.INDEX_BITS(5)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req_i(req_i),
    .pc_i(pc_i),
    .invalidate_i(invalidate_i),
    .inst_o(inst_o),
    .hold_o(hold_o),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i),
    .mem_data_i(mem_data_i)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt_o(hit_cnt_o),
    .miss_cnt_o(miss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h10) return 32'hA0 + {30'd0, a[3:2]};
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  // Instruction memory: acknowledges after wait_states idle cycles of a held request.
  assign mem_ack_i  = mem_req_o && (wcnt >= wait_states);
  assign mem_data_i = mem_word(mem_addr_o);

  always @(posedge clk_i) begin
    if (!mem_req_o || mem_ack_i) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    $display("[TB] FAIL %s: timed out waiting on DUT, required completion", name);
  endtask

  // Monitor: checks refill addresses on each acknowledge and each fetch when it is released.
  always @(negedge clk_i) begin
    if (mon_en && rst_i) begin
      if (mem_req_o) begin
        if (prev_wait) checkOutput("addr_stable", mem_addr_o, prev_addr);
        if (mem_ack_i) begin
          if (addrq.size() == 0) timeoutFail("addr_queue_empty");
          else checkOutput("refill_addr", mem_addr_o, addrq.pop_front());
        end
        prev_wait = !mem_ack_i;
        prev_addr = mem_addr_o;
      end else begin
        prev_wait = 1'b0;
      end
      if (req_i) begin
        if (hold_o) held++;
        else if (sbq.size() == 0) timeoutFail("sb_queue_empty");
        else begin
          exp_t e;
          e = sbq.pop_front();
          checkOutput("inst", inst_o, e.inst);
          checkOutput("hold_cycles", 32'(held), 32'(e.hold));
          held = 0;
        end
      end else if (!mem_req_o) begin
        checkOutput("idle_inst", inst_o, 32'd0);
        checkOutput("idle_hold", {31'd0, hold_o}, 32'd0);
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] pc, input bit inv, input int ws);
    int          idx;
    logic [27:0] line;
    bit          hit;
    int          nref;
    int          budget;
    exp_t        e;
    idx  = int'(pc[8:4]);
    line = pc[31:4];
    hit  = resident.exists(idx) && (resident[idx] == line);
    nref = hit ? 0 : (inv ? 2 : 1);
    for (int r = 0; r < nref; r++)
      for (int w = 0; w < 4; w++) addrq.push_back({line, w[1:0], 2'b00});
    e.pc   = pc;
    e.inst = mem_word({pc[31:2], 2'b00});
    e.hold = nref * (1 + 4 * (ws + 1));
    sbq.push_back(e);
    if (!hit) begin
      if (inv) resident.delete();
      resident[idx] = line;
    end
    exp_hits++;
    exp_misses += nref;
    @(posedge clk_i); #1;
    wait_states = ws;
    pc_i  = pc;
    req_i = 1'b1;
    if (inv && !hit) begin
      budget = 100;
      do begin
        @(negedge clk_i);
        budget--;
      end while (!(mem_req_o && mem_addr_o == {line, 4'h4}) && budget > 0);
      if (budget == 0) timeoutFail("wait_word1");
      invalidate_i = 1'b1;
      @(negedge clk_i);
      invalidate_i = 1'b0;
    end
    budget = 200;
    do begin
      @(negedge clk_i);
      budget--;
    end while (hold_o && budget > 0);
    if (budget == 0) timeoutFail("fetch_release");
  endtask

  task automatic idleInvalidate();
    @(posedge clk_i); #1;
    req_i = 1'b0;
    invalidate_i = 1'b1;
    @(posedge clk_i); #1;
    invalidate_i = 1'b0;
    resident.delete();
  endtask

  initial begin
    int budget;
    logic [31:0] pc;
    #12;
    checkOutput("reset_hold", {31'd0, hold_o}, 32'd0);
    checkOutput("reset_inst", inst_o, 32'd0);
    checkOutput("reset_mem_req", {31'd0, mem_req_o}, 32'd0);
    checkOutput("reset_mem_addr", mem_addr_o, 32'd0);
`ifdef ICACHE_STATS_EN
    checkOutput("reset_hit_cnt", hit_cnt_o, 32'd0);
    checkOutput("reset_miss_cnt", miss_cnt_o, 32'd0);
`endif
    @(negedge clk_i);
    rst_i  = 1'b1;
    mon_en = 1'b1;

    applyStimulus(32'h0000_0104, 1'b0, 0);
    applyStimulus(32'h0000_0000, 1'b0, 0);
    applyStimulus(32'h0000_0200, 1'b0, 0);
    applyStimulus(32'h0000_0000, 1'b0, 0);
`ifdef ICACHE_STATS_EN
    checkOutput("conflict_miss_cnt", miss_cnt_o, 32'd4);
`endif
    applyStimulus(32'h0000_1234, 1'b0, 2);
    applyStimulus(32'h0000_1238, 1'b0, 2);
    applyStimulus(32'h0000_2048, 1'b1, 1);
    idleInvalidate();
    applyStimulus(32'h0000_0104, 1'b0, 0);

    for (int i = 0; i < 150; i++) begin
      pc = $urandom_range(0, 32'h1FFF) & 32'hFFFF_FFFC;
      applyStimulus(pc, ($urandom_range(0, 9) == 0), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 19) == 0) idleInvalidate();
    end

    @(posedge clk_i); #1;
    req_i = 1'b0;
    @(negedge clk_i);
`ifdef ICACHE_STATS_EN
    checkOutput("hit_cnt", hit_cnt_o, 32'(exp_hits));
    checkOutput("miss_cnt", miss_cnt_o, 32'(exp_misses));
`endif

    idleInvalidate();
    mon_en = 1'b0;
    wait_states = 0;
    pc_i  = 32'h0000_0A30;
    req_i = 1'b1;
    budget = 100;
    do begin
      @(negedge clk_i);
      budget--;
    end while (!(mem_req_o && mem_addr_o == 32'h0000_0A38) && budget > 0);
    if (budget == 0) timeoutFail("wait_k2");
    rst_i = 1'b0;
    #1;
    checkOutput("rst_mid_mem_req", {31'd0, mem_req_o}, 32'd0);
    checkOutput("rst_mid_hold", {31'd0, hold_o}, 32'd0);
    checkOutput("rst_mid_inst", inst_o, 32'd0);
    @(posedge clk_i); #1;
    req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    held = 0;
    prev_wait = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
    resident.delete();
    mon_en = 1'b1;
    applyStimulus(32'h0000_0A30, 1'b0, 0);

`ifdef ICACHE_STATS_EN
    @(posedge clk_i); #1;
    req_i = 1'b0;
    @(negedge clk_i);
    checkOutput("post_reset_miss_cnt", miss_cnt_o, 32'd1);
    force dut.hit_cnt_o = 32'hFFFF_FFFF;
    @(negedge clk_i);
    release dut.hit_cnt_o;
    applyStimulus(32'h0000_0A34, 1'b0, 0);
    @(posedge clk_i); #1;
    req_i = 1'b0;
    @(negedge clk_i);
    checkOutput("hit_cnt_wrap", hit_cnt_o, 32'd0);
`endif

    @(posedge clk_i); #1;
    req_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("sb_drained", 32'(sbq.size()), 32'd0);
    checkOutput("addr_drained", 32'(addrq.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
